mcs4_bus_tracer: RTL and testbench

Passive instruction-fetch tracer attached to the MCS-4 system bus alongside MCS4_CPU and MCS4_MEM. It follows the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) using SYNC_N and reconstructs each fetched 12-bit address and 8-bit opcode. It also captures the RAM bank select. Each record is pushed into a small FIFO and drained through a valid/ready port, for a bench monitor or a debug UART.

---
 rtl/mcs4_bus_tracer.sv | 208 ++++++++++++++++++++
 tb/tb_mcs4_bus_tracer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_bus_tracer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mcs4_bus_tracer
// Description : Passive instruction-fetch tracer for the MCS-4 system bus.
//               Follows the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2
//               X3) from SYNC_N and rebuilds each fetch as a 24-bit record
//               {bank, address, opcode}. Records are queued in a small FIFO
//               and drained through a valid/ready port.
// Ports       : CLK, RES (async, active high)  - clock / reset
//               ENABLE                          - gate for record pushes
//               SYNC_N, DATA, CM_ROM_N, CM_RAM_N - observed bus signals
//               TRACE_VALID/READY/DATA          - record output handshake
//               LOCKED, PHASE_ERR, OVERFLOW,
//               DROP_CNT, CLR_FLAGS             - status and flag clear
// Revision    : 1.0 - initial release
// ============================================================================
module mcs4_bus_tracer #(
   parameter int DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        ENABLE,
   input  logic        SYNC_N,
   input  logic [3:0]  DATA,
   input  logic        CM_ROM_N,
   input  logic [3:0]  CM_RAM_N,
   input  logic        TRACE_READY,
   output logic        TRACE_VALID,
   output logic [23:0] TRACE_DATA,
   output logic        LOCKED,
   output logic        PHASE_ERR,
   output logic        OVERFLOW,
   output logic [7:0]  DROP_CNT,
   input  logic        CLR_FLAGS
);

   localparam int AW = $clog2(DEPTH);

   // Bus phase encoding
   localparam logic [2:0] c_PH_A1 = 3'd0;
   localparam logic [2:0] c_PH_A2 = 3'd1;
   localparam logic [2:0] c_PH_A3 = 3'd2;
   localparam logic [2:0] c_PH_M1 = 3'd3;
   localparam logic [2:0] c_PH_M2 = 3'd4;
   localparam logic [2:0] c_PH_X3 = 3'd7;
   localparam logic [2:0] c_PH_STEP = 3'd1;

   localparam logic [AW:0] c_PTR_STEP = {{AW{1'b0}}, 1'b1};
   localparam logic [7:0]  c_DROP_MAX = 8'hFF;
   localparam logic [7:0]  c_DROP_ONE = 8'd1;

   // Phase tracking and capture
   logic [2:0]  r_ph;
   logic        r_locked;
   logic        r_partial;
   logic [11:0] r_addr;
   logic [3:0]  r_bank;
   logic [3:0]  r_opr;

   // Status flags
   logic        r_phase_err;
   logic        r_overflow;
   logic [7:0]  r_drop_cnt;

   // FIFO
   logic [23:0] r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_valid;
   logic [23:0] r_head;

   logic        w_sync_early;
   logic        w_sync_missing;
   logic        w_push_req;
   logic        w_pop;
   logic        w_full;
   logic        w_push;
   logic        w_drop;
   logic [AW:0] w_rd_next;
   logic [23:0] w_record;
   logic        w_unused;

   // The ROM command line carries no information the tracer needs.
   assign w_unused = CM_ROM_N;

   assign w_sync_early   = !SYNC_N && (r_ph != c_PH_X3);
   assign w_sync_missing =  SYNC_N && (r_ph == c_PH_X3);

   // A resync on the M2 edge itself aborts that record as well.
   assign w_push_req = (r_ph == c_PH_M2) && SYNC_N && r_locked && ENABLE && !r_partial;
   assign w_record   = {r_bank, r_addr, r_opr, DATA};

   assign w_pop  = r_valid && TRACE_READY;
   assign w_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push = w_push_req && (!w_full || w_pop);
   assign w_drop = w_push_req && w_full && !w_pop;

   assign w_rd_next = w_pop ? (r_rd_ptr + c_PTR_STEP) : r_rd_ptr;

   // ------------------------------------------------------------------------
   // Phase counter, lock state and field capture
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_ph      <= c_PH_A1;
         r_locked  <= 1'b0;
         r_partial <= 1'b1;
         r_addr    <= 12'd0;
         r_bank    <= 4'd0;
         r_opr     <= 4'd0;
      end else begin
         if (!SYNC_N) begin
            r_ph     <= c_PH_A1;
            r_locked <= 1'b1;
         end else begin
            r_ph <= r_ph + c_PH_STEP;
            if (r_ph == c_PH_X3) begin
               r_locked <= 1'b0;
            end
         end

         // A record is trustworthy only if the tracer was locked during its
         // A1; a resync anywhere later poisons it until the next A1.
         if (w_sync_early) begin
            r_partial <= 1'b1;
         end else if (r_ph == c_PH_A1) begin
            r_partial <= ~r_locked;
         end

         case (r_ph)
            c_PH_A1: r_addr[3:0]  <= DATA;
            c_PH_A2: r_addr[7:4]  <= DATA;
            c_PH_A3: begin
               r_addr[11:8] <= DATA;
               r_bank       <= ~CM_RAM_N;
            end
            c_PH_M1: r_opr <= DATA;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Sticky status flags; a clear wins over a same-cycle setting event
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_phase_err <= 1'b0;
         r_overflow  <= 1'b0;
         r_drop_cnt  <= 8'd0;
      end else if (CLR_FLAGS) begin
         r_phase_err <= 1'b0;
         r_overflow  <= 1'b0;
         r_drop_cnt  <= 8'd0;
      end else begin
         if (w_sync_early || w_sync_missing) begin
            r_phase_err <= 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != c_DROP_MAX) begin
               r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Record storage
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_record;
      end
   end

   // The output stage looks at the FIFO as it stood before this edge's
   // write, so a fresh record appears one edge after it is pushed and a
   // popped head is never presented twice.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_valid  <= 1'b0;
         r_head   <= 24'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_STEP;
         end
         r_rd_ptr <= w_rd_next;
         r_valid  <= (w_rd_next != r_wr_ptr);
         if (w_rd_next != r_wr_ptr) begin
            r_head <= r_mem[w_rd_next[AW-1:0]];
         end
      end
   end

   assign TRACE_VALID = r_valid;
   assign TRACE_DATA  = r_head;
   assign LOCKED      = r_locked;
   assign PHASE_ERR   = r_phase_err;
   assign OVERFLOW    = r_overflow;
   assign DROP_CNT    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mcs4_bus_tracer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mcs4_bus_tracer
// Description : Self-checking bench for mcs4_bus_tracer. Stimulus is issued
//               as whole instruction cycles; a transaction-level model
//               predicts which records reach the FIFO and the flag state,
//               and a monitor compares every presented head record.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcs4_bus_tracer;

   localparam int DEPTH = 8;

   logic        CLK = 1'b0;
   logic        RES = 1'b1;
   logic        ENABLE = 1'b0;
   logic        SYNC_N = 1'b1;
   logic [3:0]  DATA = 4'd0;
   logic        CM_ROM_N = 1'b1;
   logic [3:0]  CM_RAM_N = 4'hF;
   logic        TRACE_READY = 1'b0;
   logic        CLR_FLAGS = 1'b0;
   logic        TRACE_VALID;
   logic [23:0] TRACE_DATA;
   logic        LOCKED;
   logic        PHASE_ERR;
   logic        OVERFLOW;
   logic [7:0]  DROP_CNT;

   mcs4_bus_tracer #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RES(RES), .ENABLE(ENABLE), .SYNC_N(SYNC_N), .DATA(DATA),
      .CM_ROM_N(CM_ROM_N), .CM_RAM_N(CM_RAM_N), .TRACE_READY(TRACE_READY),
      .TRACE_VALID(TRACE_VALID), .TRACE_DATA(TRACE_DATA), .LOCKED(LOCKED),
      .PHASE_ERR(PHASE_ERR), .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT),
      .CLR_FLAGS(CLR_FLAGS)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [23:0] exp_q[$];
   bit m_locked = 1'b0;
   bit m_perr = 1'b0;
   bit m_perr_known = 1'b1;
   bit m_ovf = 1'b0;
   int m_drop = 0;

   int ready_pct = 100;
   bit ready_m2_only = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_push(input logic [23:0] rec);
      if (exp_q.size() < DEPTH) begin
         exp_q.push_back(rec);
      end else begin
         m_ovf = 1'b1;
         if (m_drop < 255) m_drop++;
      end
   endtask

   task automatic check_flags();
      chk("locked", {31'd0, LOCKED}, {31'd0, m_locked});
      chk("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
      chk("drop_cnt", {24'd0, DROP_CNT}, m_drop);
      if (m_perr_known) chk("phase_err", {31'd0, PHASE_ERR}, {31'd0, m_perr});
   endtask

   // One bus phase: inputs change 1 ns after the edge that ends the prior phase.
   task automatic drive_phase(input logic s, input logic [3:0] d, input logic [3:0] rn,
                              input int idx, input bit clr);
      @(posedge CLK);
      #1;
      SYNC_N      = s;
      DATA        = d;
      CM_RAM_N    = rn;
      CM_ROM_N    = (idx == 3) ? 1'b0 : 1'b1;
      CLR_FLAGS   = clr;
      TRACE_READY = ready_m2_only ? (idx == 4) : (int'($urandom_range(99)) < ready_pct);
   endtask

   // kind 0: aligned cycle; 1: SYNC_N withheld at X3; 2: SYNC_N low at phase k.
   task automatic run_cycle(input int kind, input int k, input bit en,
                            input logic [11:0] a, input logic [7:0] op,
                            input logic [3:0] bn, input bit clr);
      bit start_locked;
      logic [3:0] nib;
      start_locked = m_locked;
      ENABLE = en;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: nib = a[3:0];
            1: nib = a[7:4];
            2: nib = a[11:8];
            3: nib = op[7:4];
            4: nib = op[3:0];
            default: nib = 4'($urandom);
         endcase
         if (kind == 2 && i == k) begin
            drive_phase(1'b0, nib, bn, i, 1'b0);
            m_locked = 1'b1;
            m_perr = 1'b1;
            return;
         end
         drive_phase((i == 7) ? (kind == 1) : 1'b1, nib, bn, i, clr && (i == 1));
         if (i == 0) begin
            @(negedge CLK);
            check_flags();
         end
         if (i == 1 && clr) begin
            m_perr = 1'b0; m_perr_known = 1'b1; m_ovf = 1'b0; m_drop = 0;
         end
         if (i == 4) begin
            @(negedge CLK);
            #1;
            if (start_locked && en) model_push({~bn, a, op});
         end
         if (i == 7) begin
            if (kind == 1) begin
               m_locked = 1'b0; m_perr = 1'b1;
            end else begin
               m_locked = 1'b1;
            end
         end
      end
   endtask

   task automatic rand_cycle(input int kind, input int k, input bit en, input bit clr);
      run_cycle(kind, k, en, 12'($urandom), 8'($urandom), 4'($urandom), clr);
   endtask

   // Random bus activity with SYNC_N high, then a single SYNC_N low phase.
   task automatic pre_lock(input int n);
      for (int i = 0; i < n; i++) drive_phase(1'b1, 4'($urandom), 4'($urandom), 0, 1'b0);
      @(negedge CLK);
      chk("prelock_locked", {31'd0, LOCKED}, 32'd0);
      chk("prelock_valid", {31'd0, TRACE_VALID}, 32'd0);
      m_perr_known = 1'b0;
      drive_phase(1'b0, 4'($urandom), 4'hF, 7, 1'b0);
      m_locked = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'd0, TRACE_VALID}, 32'd0);
      chk({tag, "_data"}, {8'd0, TRACE_DATA}, 32'd0);
      chk({tag, "_locked"}, {31'd0, LOCKED}, 32'd0);
      chk({tag, "_phase_err"}, {31'd0, PHASE_ERR}, 32'd0);
      chk({tag, "_overflow"}, {31'd0, OVERFLOW}, 32'd0);
      chk({tag, "_drop_cnt"}, {24'd0, DROP_CNT}, 32'd0);
   endtask

   // Monitor: every presented head must be the oldest outstanding record.
   initial begin
      forever begin
         @(negedge CLK);
         if (TRACE_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_record: got %0h expected no record", TRACE_DATA);
            end else begin
               chk("head_record", {8'd0, TRACE_DATA}, {8'd0, exp_q[0]});
               if (TRACE_READY) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      int kind, k, kk, rsel;
      bit en;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      RES = 1'b0;

      // Pre-lock activity, lock, then the reference fetch.
      pre_lock(8);
      ready_pct = 100;
      ENABLE = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [3:0] nib;
         case (i)
            0: nib = 4'd4;
            1: nib = 4'd3;
            2: nib = 4'd2;
            3: nib = 4'd1;
            4: nib = 4'd5;
            default: nib = 4'($urandom);
         endcase
         drive_phase((i == 7) ? 1'b0 : 1'b1, nib, 4'b1110, i, i == 1);
         if (i == 1) begin
            m_perr = 1'b0; m_perr_known = 1'b1; m_ovf = 1'b0; m_drop = 0;
         end
         if (i == 4) begin
            @(negedge CLK);
            #1;
            model_push(24'h123415);
         end
         if (i == 5) begin
            @(negedge CLK);
            chk("basic_valid_x1", {31'd0, TRACE_VALID}, 32'd0);
         end
         if (i == 6) begin
            @(negedge CLK);
            chk("basic_valid_x2", {31'd0, TRACE_VALID}, 32'd1);
            chk("basic_data", {8'd0, TRACE_DATA}, 32'h123415);
            chk("basic_locked", {31'd0, LOCKED}, 32'd1);
         end
      end
      m_locked = 1'b1;
      rand_cycle(0, 0, 1'b1, 1'b0);

      // SYNC_N low at M1, then aligned cycles; then SYNC_N withheld at X3.
      rand_cycle(2, 3, 1'b1, 1'b0);
      rand_cycle(0, 0, 1'b1, 1'b0);
      rand_cycle(0, 0, 1'b1, 1'b1);
      rand_cycle(1, 0, 1'b1, 1'b0);
      rand_cycle(0, 0, 1'b1, 1'b0);
      rand_cycle(0, 0, 1'b1, 1'b0);

      // Overflow: ten fetches into a stalled FIFO.
      ready_pct = 0;
      rand_cycle(0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) rand_cycle(0, 0, 1'b1, 1'b0);
      rand_cycle(0, 0, 1'b0, 1'b0);
      chk("ovf_flag", {31'd0, OVERFLOW}, 32'd1);
      chk("ovf_drop_cnt", {24'd0, DROP_CNT}, 32'd2);

      // Full FIFO with a pop exactly at the M2 edge.
      ready_m2_only = 1'b1;
      rand_cycle(0, 0, 1'b1, 1'b0);
      ready_m2_only = 1'b0;
      rand_cycle(0, 0, 1'b0, 1'b0);
      chk("full_pop_drop_cnt", {24'd0, DROP_CNT}, 32'd2);

      // Drain in push order, then clear the flags.
      ready_pct = 100;
      rand_cycle(0, 0, 1'b0, 1'b0);
      rand_cycle(0, 0, 1'b0, 1'b0);
      @(negedge CLK);
      chk("drained_valid", {31'd0, TRACE_VALID}, 32'd0);
      chk("drained_outstanding", exp_q.size(), 32'd0);
      rand_cycle(0, 0, 1'b0, 1'b1);
      rand_cycle(0, 0, 1'b0, 1'b0);
      chk("clr_overflow", {31'd0, OVERFLOW}, 32'd0);
      chk("clr_drop_cnt", {24'd0, DROP_CNT}, 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         rsel = int'($urandom_range(3));
         ready_pct = (rsel == 0) ? 0 : (rsel == 1) ? 20 : (rsel == 2) ? 60 : 100;
         kind = int'($urandom_range(99));
         kind = (kind < 78) ? 0 : (kind < 88) ? 1 : 2;
         kk = int'($urandom_range(5));
         k = (kk < 4) ? kk : kk + 1;
         en = (int'($urandom_range(99)) < 85);
         rand_cycle(kind, k, en, (kind == 0) && (int'($urandom_range(19)) == 0));
      end

      // Async reset in M1 with three records queued.
      ready_pct = 100;
      rand_cycle(0, 0, 1'b0, 1'b1);
      rand_cycle(0, 0, 1'b0, 1'b0);
      rand_cycle(0, 0, 1'b0, 1'b0);
      ready_pct = 0;
      for (int i = 0; i < 3; i++) rand_cycle(0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive_phase(1'b1, 4'($urandom), 4'hF, i, 1'b0);
      @(negedge CLK);
      chk("queued_before_reset", {31'd0, TRACE_VALID}, 32'd1);
      @(posedge CLK);
      #3;
      RES = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      m_locked = 1'b0; m_perr = 1'b0; m_perr_known = 1'b1; m_ovf = 1'b0; m_drop = 0;
      repeat (2) @(posedge CLK);
      #1;
      RES = 1'b0;

      // Recovery: nothing until a SYNC_N and a full cycle.
      ready_pct = 100;
      pre_lock(int'($urandom_range(12, 3)));
      rand_cycle(0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) rand_cycle(0, 0, 1'b1, 1'b0);
      rand_cycle(0, 0, 1'b0, 1'b0);
      @(negedge CLK);
      chk("final_outstanding", exp_q.size(), 32'd0);
      chk("final_valid", {31'd0, TRACE_VALID}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
